// File: rtl/rotating_counter_bank.sv
// Bank of seeded up/down counters feeding a rotating output register ring.
// Optional per-channel wrap pulse output is enabled by defining WRAP_FLAG_EN.
module rotating_counter_bank #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          latch,
  input  logic                          rot_dir,
  input  logic                          hold,
  output logic [CHANNELS*WIDTH-1:0]     out_flat,
  output logic [$clog2(CHANNELS)-1:0]   phase
`ifdef WRAP_FLAG_EN
  ,
  output logic [CHANNELS-1:0]           wrap
`endif
);

  localparam int unsigned PW         = $clog2(CHANNELS);
  localparam int unsigned SEED_SHIFT = WIDTH - PW;

  logic [WIDTH-1:0] out_q [CHANNELS];
  logic [PW-1:0]    phase_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    localparam int unsigned     NEXT_IDX = (g + 1) % CHANNELS;
    localparam int unsigned     PREV_IDX = (g + CHANNELS - 1) % CHANNELS;
    localparam bit              IS_UP    = (g % 2) == 1;
    localparam logic [WIDTH-1:0] SEED    = WIDTH'(g) << SEED_SHIFT;
    localparam logic [WIDTH-1:0] WRAP_AT = IS_UP ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_step;

    assign count_step = IS_UP ? count_q + WIDTH'(1) : count_q - WIDTH'(1);

    // Free-running counter; odd channels count up, even channels count down.
    always_ff @(posedge clock) begin
      if (reset) begin
        count_q <= SEED;
      end else if (!hold) begin
        count_q <= count_step;
      end
    end

    // Output ring: snapshot the pre-update count or take a neighbour's value.
    always_ff @(posedge clock) begin
      if (reset) begin
        out_q[g] <= SEED;
      end else if (latch) begin
        out_q[g] <= count_q;
      end else if (rot_dir) begin
        out_q[g] <= out_q[PREV_IDX];
      end else begin
        out_q[g] <= out_q[NEXT_IDX];
      end
    end

    assign out_flat[g*WIDTH +: WIDTH] = out_q[g];

`ifdef WRAP_FLAG_EN
    logic wrap_q;

    // Pulses alongside the first cycle the counter shows its post-wrap value.
    always_ff @(posedge clock) begin
      if (reset) begin
        wrap_q <= 1'b0;
      end else begin
        wrap_q <= !hold && (count_q == WRAP_AT);
      end
    end

    assign wrap[g] = wrap_q;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q <= '0;
    end else if (latch) begin
      phase_q <= '0;
    end else if (rot_dir) begin
      phase_q <= phase_q - PW'(1);
    end else begin
      phase_q <= phase_q + PW'(1);
    end
  end

  assign phase = phase_q;

endmodule

// File: tb/tb_rotating_counter_bank.sv
// Directed bench for rotating_counter_bank: 4-channel vector table plus
// hand-written hold, free-run, wrap and 2-channel reset sequences.
module tb_rotating_counter_bank;

  logic        clock = 1'b0;
  logic        reset4, latch4, rot_dir4, hold4;
  logic [31:0] out4;
  logic [1:0]  phase4;
  logic        reset2, latch2, rot_dir2, hold2;
  logic [15:0] out2;
  logic [0:0]  phase2;
`ifdef WRAP_FLAG_EN
  logic [3:0]  wrap4;
  logic [1:0]  wrap2;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clock = ~clock;

  rotating_counter_bank #(.WIDTH(8), .CHANNELS(4)) dut4 (
    .clock    (clock),
    .reset    (reset4),
    .latch    (latch4),
    .rot_dir  (rot_dir4),
    .hold     (hold4),
    .out_flat (out4),
    .phase    (phase4)
`ifdef WRAP_FLAG_EN
    ,
    .wrap     (wrap4)
`endif
  );

  rotating_counter_bank #(.WIDTH(8), .CHANNELS(2)) dut2 (
    .clock    (clock),
    .reset    (reset2),
    .latch    (latch2),
    .rot_dir  (rot_dir2),
    .hold     (hold2),
    .out_flat (out2),
    .phase    (phase2)
`ifdef WRAP_FLAG_EN
    ,
    .wrap     (wrap2)
`endif
  );

  typedef struct {
    logic        latch;
    logic        rot_dir;
    logic        hold;
    logic [31:0] exp_out;
    logic [1:0]  exp_phase;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive4(input logic l, input logic r, input logic h);
    latch4   = l;
    rot_dir4 = r;
    hold4    = h;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'hC0804000, 2'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h00C08040, 2'd1};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h4000C080, 2'd2};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h804000C0, 2'd3};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'hC0804000, 2'd0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h804000C0, 2'd3};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'hC67A46FA, 2'd0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 32'hFAC67A46, 2'd1};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 32'hC77947F9, 2'd0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 32'hC77947F9, 2'd0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 32'hC87848F8, 2'd0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 32'h7848F8C8, 2'd3};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 32'hC87848F8, 2'd0};

    reset4 = 1'b1; drive4(1'b0, 1'b0, 1'b0);
    reset2 = 1'b1; latch2 = 1'b0; rot_dir2 = 1'b0; hold2 = 1'b0;

    // 4-channel: reset state
    tick();
    check("reset_out4", out4, 32'hC0804000);
    check("reset_phase4", 32'(phase4), 32'd0);
    reset4 = 1'b0;

    for (int i = 0; i < 13; i++) begin
      drive4(vecs[i].latch, vecs[i].rot_dir, vecs[i].hold);
      tick();
      check($sformatf("vec%0d_out", i), out4, vecs[i].exp_out);
      check($sformatf("vec%0d_phase", i), 32'(phase4), 32'(vecs[i].exp_phase));
    end

    // Counters are now {F5,4B,75,CB}; a 10-cycle hold must not move them.
    drive4(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
`ifdef WRAP_FLAG_EN
      check($sformatf("hold_wrap%0d", i), 32'(wrap4), 32'd0);
`endif
    end
    drive4(1'b1, 1'b0, 1'b0);
    tick();
    check("hold_snapshot", out4, 32'hCB754BF5);
    check("hold_snapshot_phase", 32'(phase4), 32'd0);

    // Reset mid-rotation, then held at the seeds, then 64 free cycles.
    drive4(1'b0, 1'b1, 1'b0);
    tick();
    tick();
    reset4 = 1'b1;
    tick();
    check("midreset_out4", out4, 32'hC0804000);
    check("midreset_phase4", 32'(phase4), 32'd0);
    reset4 = 1'b0;
    drive4(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
`ifdef WRAP_FLAG_EN
      check($sformatf("seed_hold_wrap%0d", i), 32'(wrap4), 32'd0);
`endif
    end
    drive4(1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 64; c++) begin
      tick();
`ifdef WRAP_FLAG_EN
      check($sformatf("wrap_cycle%0d", c), 32'(wrap4),
            (c == 1) ? 32'h1 : (c == 64) ? 32'h8 : 32'h0);
`endif
    end
    drive4(1'b1, 1'b0, 1'b0);
    tick();
    check("freerun64_out4", out4, 32'h004080C0);
`ifdef WRAP_FLAG_EN
    check("wrap_after64", 32'(wrap4), 32'h0);
`endif

    // 2-channel instance
    tick();
    check("reset_out2", 32'(out2), 32'h8000);
    check("reset_phase2", 32'(phase2), 32'd0);
    reset2 = 1'b0;
    latch2 = 1'b1;
    tick();
    check("ch2_latch1", 32'(out2), 32'h8000);
    tick();
    check("ch2_latch2", 32'(out2), 32'h81FF);
    tick();
    check("ch2_latch3", 32'(out2), 32'h82FE);
    latch2 = 1'b0;
    tick();
    check("ch2_swap1", 32'(out2), 32'hFE82);
    check("ch2_swap1_phase", 32'(phase2), 32'd1);
    rot_dir2 = 1'b1;
    tick();
    check("ch2_swap2", 32'(out2), 32'h82FE);
    check("ch2_swap2_phase", 32'(phase2), 32'd0);
    rot_dir2 = 1'b0;
    tick();
    reset2 = 1'b1;
    tick();
    check("ch2_midreset", 32'(out2), 32'h8000);
    check("ch2_midreset_phase", 32'(phase2), 32'd0);
    reset2 = 1'b0;
    tick();
    check("ch2_after_reset", 32'(out2), 32'h0080);
    check("ch2_after_reset_phase", 32'(phase2), 32'd1);
    latch2 = 1'b1;
    tick();
    check("ch2_after_reset_latch", 32'(out2), 32'h81FF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/rotating_counter_bank.md
# rotating_counter_bank

Parametrised bank of free-running counters with a rotating output register file, succeeding the two-channel alternating counter pair. Each channel holds one up- or down-counter seeded at evenly spaced offsets. An output register per channel either snapshots all counters at once or rotates its contents around the ring in either direction, reporting the ring position. It sits in the tick-level demo datapath as a multi-channel pattern and test-stimulus source.

## Interface
- WIDTH, 8: counter and output width in bits; must satisfy WIDTH ≥ log2(CHANNELS).
- CHANNELS, 4: channel count; a power of two, ≥ 2.
- clock  in  1  sole clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- latch  in  1  1 = snapshot counters into outputs; 0 = rotate outputs.
- rot_dir  in  1  rotation direction, used when latch=0: 0 = toward lower index, 1 = toward higher index.
- hold  in  1  1 = freeze all counters; has no effect on outputs.
- out_flat  out  CHANNELS*WIDTH  output registers; channel i occupies [i*WIDTH +: WIDTH].
- phase  out  $clog2(CHANNELS)  ring offset since the last latch.
- wrap  out  CHANNELS  per-channel wrap flag; present only with WRAP_FLAG_EN.

## Operation
- Seed for channel i: i * 2^WIDTH / CHANNELS. With WIDTH=8, CHANNELS=4 the seeds are 00, 40, 80, C0.
- Even channels decrement and odd channels increment, by 1 per cycle modulo 2^WIDTH.
- hold=1 leaves all counters unchanged.
- latch=1: out[i] ← count[i], using the pre-update value at the edge; phase ← 0.
- latch=0, rot_dir=0: out[i] ← out[(i+1) mod CHANNELS]; phase ← phase+1 mod CHANNELS.
- latch=0, rot_dir=1: out[i] ← out[(i−1) mod CHANNELS]; phase ← phase−1 mod CHANNELS.
- Output rotation is independent of hold.
- Reset:
  - count[i] ← seed[i] and out[i] ← seed[i].
  - phase ← 0 and wrap ← 0.
  - Reset dominates latch, hold and rot_dir.
- Reset asserted mid-rotation discards the ring contents; the next cycle behaves as the first cycle after reset.

## Timing
- All outputs are registered, with no combinational paths from inputs to outputs.
- Latch latency is 1 cycle: out shows the counter values present before the edge on which latch=1 was sampled.
- Rotation moves one position per cycle; CHANNELS consecutive rotations in one direction restore the original order with phase=0.
- Wrap-around is silent modulo arithmetic:
  - Down-channel: 00 → FF.
  - Up-channel: FF → 00.
- Back-to-back latch cycles re-snapshot every cycle.
- Changing rot_dir between cycles is legal; phase tracks the net offset.

## Configuration
- WRAP_FLAG_EN defined:
  - The wrap port exists.
  - wrap[i] is registered and high for exactly the one cycle in which count[i] holds its post-wrap value (00 for up-channels, FF for down-channels).
  - wrap[i] is 0 while hold=1.
- WRAP_FLAG_EN undefined: the wrap port and its logic are absent; all other behaviour is identical.

## Test plan
- CHANNELS=4, WIDTH=8; reset 1 cycle, then latch=1 for 1 cycle → out = {00,40,80,C0}, phase=0; counters become {FF,41,7F,C1}.
- Then latch=0, rot_dir=0 for 1 cycle → out = {40,80,C0,00}, phase=1. Three more cycles → out = {00,40,80,C0}, phase=0.
- latch=0, rot_dir=1 for 1 cycle after a snapshot of {00,40,80,C0} → out = {C0,00,40,80}, phase=3.
- hold=1 for 10 cycles, then latch=1 → snapshot equals the values present when hold rose; no wrap pulses occur while held.
- WRAP_FLAG_EN: after reset, wrap[0] is high in the first cycle (count 00→FF); wrap[3] is high in cycle 64 (C0+64 = 00); each pulse lasts 1 cycle.
- CHANNELS=2: reset then free-run → counts follow 00→FF→FE… and 80→81→82…; latch=0 makes out[0] and out[1] swap every cycle; reset mid-stream returns out to {00,80} on the next cycle.
